// File: rtl/conv_postproc_pipe.sv
// rtl/conv_postproc_pipe.sv - per-channel bias, ReLU and requantisation pipeline after the conv PE array
module conv_postproc_pipe #(
    parameter int LANES   = 40,
    parameter int ACC_W   = 32,
    parameter int BIAS_W  = 16,
    parameter int SCALE_W = 16,
    parameter int OUT_W   = 8,
    parameter int CH_NUM  = 32,
    parameter int CH_AW   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [CH_AW-1:0]       cfg_addr,
    input  logic [15:0]            cfg_data,
    input  logic                   relu_en,
    input  logic                   round_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH_AW-1:0]       in_ch,
    input  logic [LANES*ACC_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [CH_AW-1:0]       out_ch,
    output logic                   out_sat
);

    localparam int P_W = ACC_W + SCALE_W + 1;
    localparam logic signed [P_W-1:0] Q_MAX = P_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [P_W-1:0] Q_MIN = P_W'(-(2 ** (OUT_W - 1)));

    // acc + bias, clamped to the signed accumulator range
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [BIAS_W-1:0] b);
        logic signed [ACC_W:0] t;
        t = (ACC_W + 1)'($signed(a)) + (ACC_W + 1)'($signed(b));
        if (t[ACC_W] != t[ACC_W-1]) begin
            return {t[ACC_W], {(ACC_W - 1){~t[ACC_W]}}};
        end
        return t[ACC_W-1:0];
    endfunction

    // returns {clamped, q}; the product width holds any scale*acc plus rounding term
    function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0]   r,
                                               input logic [SCALE_W-1:0] sc,
                                               input logic [4:0]         sh,
                                               input logic               rnd);
        logic signed [P_W-1:0] p;
        logic signed [P_W-1:0] q;
        logic                  sat;
        p = P_W'($signed(r)) * P_W'($signed({1'b0, sc}));
        if (rnd && sh != 5'd0) begin
            p = p + (P_W'(1) << (sh - 5'd1));
        end
        q   = p >>> sh;
        sat = 1'b1;
        if (q > Q_MAX) begin
            q = Q_MAX;
        end else if (q < Q_MIN) begin
            q = Q_MIN;
        end else begin
            sat = 1'b0;
        end
        return {sat, q[OUT_W-1:0]};
    endfunction

    logic [CH_NUM-1:0][BIAS_W-1:0]  bias_tab;
    logic [CH_NUM-1:0][SCALE_W-1:0] scale_tab;
    logic [CH_NUM-1:0][4:0]         shift_tab;

    logic [31:0] cfg_idx;
    logic [31:0] in_idx;
    assign cfg_idx = 32'(cfg_addr);
    assign in_idx  = 32'(in_ch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_tab  <= '0;
            shift_tab <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                scale_tab[i] <= SCALE_W'(1);
            end
        end else if (cfg_we && cfg_idx < CH_NUM) begin
            case (cfg_sel)
                2'd0:    bias_tab[cfg_addr]  <= cfg_data[BIAS_W-1:0];
                2'd1:    scale_tab[cfg_addr] <= cfg_data[SCALE_W-1:0];
                2'd2:    shift_tab[cfg_addr] <= cfg_data[4:0];
                default: ;
            endcase
        end
    end

    // Table read sees pre-edge contents, so a same-cycle write never reaches this beat.
    logic [BIAS_W-1:0]  lk_bias;
    logic [SCALE_W-1:0] lk_scale;
    logic [4:0]         lk_shift;

    always_comb begin
        lk_bias  = '0;
        lk_scale = '0;
        lk_shift = '0;
        if (in_idx < CH_NUM) begin
            lk_bias  = bias_tab[in_ch];
            lk_scale = scale_tab[in_ch];
            lk_shift = shift_tab[in_ch];
        end
    end

    logic [LANES-1:0][ACC_W-1:0] acc_in;
    logic [LANES-1:0][ACC_W-1:0] sum_next;
    assign acc_in = in_data;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_next[i] = sat_add(acc_in[i], lk_bias);
        end
    end

    logic                        v1, v2, v3;
    logic                        ready2, ready3;
    logic [LANES-1:0][ACC_W-1:0] s1_sum;
    logic [SCALE_W-1:0]          s1_scale;
    logic [4:0]                  s1_shift;
    logic                        s1_relu, s1_round;
    logic [CH_AW-1:0]            s1_ch;
    logic [LANES-1:0][ACC_W-1:0] s2_r;
    logic [SCALE_W-1:0]          s2_scale;
    logic [4:0]                  s2_shift;
    logic                        s2_round;
    logic [CH_AW-1:0]            s2_ch;
    logic [LANES-1:0][OUT_W-1:0] s3_data;
    logic [CH_AW-1:0]            s3_ch;
    logic                        s3_sat;

    assign ready3   = !v3 || out_ready;
    assign ready2   = !v2 || ready3;
    assign in_ready = !v1 || ready2;

    logic [LANES-1:0][ACC_W-1:0] r_next;

    always_comb begin
        r_next = '0;
        for (int i = 0; i < LANES; i++) begin
            r_next[i] = (s1_relu && s1_sum[i][ACC_W-1]) ? '0 : s1_sum[i];
        end
    end

    logic [LANES-1:0][OUT_W-1:0] q_next;
    logic                        sat_next;

    always_comb begin : requant_lanes
        logic [OUT_W:0] rq;
        rq       = '0;
        q_next   = '0;
        sat_next = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            rq        = requant(s2_r[i], s2_scale, s2_shift, s2_round);
            q_next[i] = rq[OUT_W-1:0];
            sat_next  = sat_next | rq[OUT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            s1_sum   <= '0;
            s1_scale <= '0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            s1_round <= 1'b0;
            s1_ch    <= '0;
            s2_r     <= '0;
            s2_scale <= '0;
            s2_shift <= '0;
            s2_round <= 1'b0;
            s2_ch    <= '0;
            s3_data  <= '0;
            s3_ch    <= '0;
            s3_sat   <= 1'b0;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_sum   <= sum_next;
                    s1_scale <= lk_scale;
                    s1_shift <= lk_shift;
                    s1_relu  <= relu_en;
                    s1_round <= round_en;
                    s1_ch    <= in_ch;
                end
            end
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    s2_r     <= r_next;
                    s2_scale <= s1_scale;
                    s2_shift <= s1_shift;
                    s2_round <= s1_round;
                    s2_ch    <= s1_ch;
                end
            end
            if (ready3) begin
                v3 <= v2;
                if (v2) begin
                    s3_data <= q_next;
                    s3_ch   <= s2_ch;
                    s3_sat  <= sat_next;
                end
            end
        end
    end

    assign out_valid = v3;
    assign out_data  = s3_data;
    assign out_ch    = s3_ch;
    assign out_sat   = s3_sat;

endmodule

// File: tb/tb_conv_postproc_pipe.sv
// tb/tb_conv_postproc_pipe.sv - self-checking bench for conv_postproc_pipe
module tb_conv_postproc_pipe;

    localparam int LANES  = 40;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 8;
    localparam int CH_NUM = 32;
    localparam int CH_AW  = 5;
    localparam int DW     = LANES * ACC_W;
    localparam int OW     = LANES * OUT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [1:0]       cfg_sel;
    logic [CH_AW-1:0] cfg_addr;
    logic [15:0]      cfg_data;
    logic             relu_en, round_en;
    logic             in_valid, in_ready;
    logic [CH_AW-1:0] in_ch;
    logic [DW-1:0]    in_data;
    logic             out_valid, out_ready;
    logic [OW-1:0]    out_data;
    logic [CH_AW-1:0] out_ch;
    logic             out_sat;

    conv_postproc_pipe #(
        .LANES(LANES), .ACC_W(ACC_W), .BIAS_W(16), .SCALE_W(16),
        .OUT_W(OUT_W), .CH_NUM(CH_NUM), .CH_AW(CH_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .relu_en(relu_en),
        .round_en(round_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0]    data;
        logic [CH_AW-1:0] ch;
        logic             sat;
    } exp_t;

    typedef struct {
        int     do_cfg, ch, bias, scale, shift, relu, rnd;
        longint acc;
        int     expv, sat;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   mb[CH_NUM];
    int   ms[CH_NUM];
    int   msh[CH_NUM];

    task automatic chk(input bit ok, input string msg);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s", msg);
        end
    endtask

    task automatic model_defaults();
        for (int i = 0; i < CH_NUM; i++) begin
            mb[i]  = 0;
            ms[i]  = 1;
            msh[i] = 0;
        end
    endtask

    // Reference: plain integer arithmetic on each lane
    function automatic exp_t model_beat(input logic [DW-1:0] d, input int ch,
                                        input int relu, input int rnd);
        exp_t   e;
        longint s, p, q;
        int     b, sc, sh;
        b = 0; sc = 0; sh = 0;
        if (ch < CH_NUM) begin
            b = mb[ch]; sc = ms[ch]; sh = msh[ch];
        end
        e.data = '0;
        e.ch   = CH_AW'(ch);
        e.sat  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            s = longint'($signed(d[i*ACC_W +: ACC_W])) + longint'(b);
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            else if (s < -64'sd2147483648) s = -64'sd2147483648;
            if (relu != 0 && s < 0) s = 0;
            p = s * longint'(sc);
            if (rnd != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
            q = p >>> sh;
            if (q > 127) begin
                q = 127; e.sat = 1'b1;
            end else if (q < -128) begin
                q = -128; e.sat = 1'b1;
            end
            e.data[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] fill(input longint v);
        logic [ACC_W-1:0] w;
        w = ACC_W'(v);
        return {LANES{w}};
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 3) == 0) d[i*ACC_W +: ACC_W] = ACC_W'($urandom);
            else d[i*ACC_W +: ACC_W] = ACC_W'($signed(14'($urandom)));
        end
        return d;
    endfunction

    // Scoreboard, stall-hold check and model table tracking, all sampled mid-cycle
    logic [OW-1:0]    held_d;
    logic [CH_AW-1:0] held_c;
    logic             held_s;
    bit               held_v = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                chk(out_valid && out_data == held_d && out_ch == held_c && out_sat == held_s,
                    $sformatf("stall_hold got v=%b ch=%0d sat=%b data=%h want v=1 ch=%0d sat=%b data=%h",
                              out_valid, out_ch, out_sat, out_data, held_c, held_s, held_d));
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_c = out_ch;
            held_s = out_sat;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, $sformatf("unexpected_beat got ch=%0d want no beat", out_ch));
                end else begin
                    e = sb.pop_front();
                    chk(out_data == e.data && out_ch == e.ch && out_sat == e.sat,
                        $sformatf("beat got ch=%0d sat=%b data=%h want ch=%0d sat=%b data=%h",
                                  out_ch, out_sat, out_data, e.ch, e.sat, e.data));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model_beat(in_data, int'(in_ch), int'(relu_en), int'(round_en)));
            if (cfg_we && int'(cfg_addr) < CH_NUM) begin
                case (cfg_sel)
                    2'd0:    mb[cfg_addr]  = int'($signed(cfg_data));
                    2'd1:    ms[cfg_addr]  = int'(cfg_data);
                    2'd2:    msh[cfg_addr] = int'(cfg_data[4:0]);
                    default: ;
                endcase
            end
        end
    end

    task automatic cfg_wr(input int sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_addr = CH_AW'(addr);
        cfg_data = 16'(data);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; lat = cycles after accept
    task automatic send_one(input int ch, input logic [DW-1:0] d, input int relu,
                            input int rnd, output int lat);
        in_valid = 1'b1;
        in_ch    = CH_AW'(ch);
        in_data  = d;
        relu_en  = (relu != 0);
        round_en = (rnd != 0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk(sb.size() == 0, $sformatf("drain got pending=%0d want 0", sb.size()));
    endtask

    function automatic bit lanes_eq(input int v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < LANES; i++)
            if (int'($signed(out_data[i*OUT_W +: OUT_W])) != v) ok = 1'b0;
        return ok;
    endfunction

    initial begin
        vec_t vecs[15];
        int   pat[6] = '{1, 0, 0, 1, 0, 1};
        int   lat, n, sent;
        int   got[2];
        bit   ok;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
        relu_en = 1'b0; round_en = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
        out_ready = 1'b1;
        model_defaults();

        //           cfg ch  bias  scale  sh relu rnd  acc         exp  sat
        vecs[0]  = '{0,  0,  0,    1,     0, 0,   0,   100,        100, 0};
        vecs[1]  = '{1,  2,  -50,  1,     0, 1,   0,   30,         0,   0};
        vecs[2]  = '{1,  2,  -50,  1,     0, 0,   0,   30,         -20, 0};
        vecs[3]  = '{1,  3,  0,    3,     2, 0,   1,   10,         8,   0};
        vecs[4]  = '{1,  3,  0,    3,     2, 0,   0,   10,         7,   0};
        vecs[5]  = '{1,  3,  0,    3,     2, 0,   1,   -10,        -7,  0};
        vecs[6]  = '{1,  3,  0,    3,     2, 1,   1,   -10,        0,   0};
        vecs[7]  = '{1,  4,  0,    1,     0, 0,   0,   1000,       127, 1};
        vecs[8]  = '{1,  4,  0,    1,     0, 0,   0,   -1000,      -128, 1};
        vecs[9]  = '{1,  5,  1,    1,     0, 0,   0,   2147483647, 127, 1};
        vecs[10] = '{1,  6,  0,    65535, 16, 0,  1,   -3,         -3,  0};
        vecs[11] = '{1,  31, 0,    2,     0, 0,   0,   50,         100, 0};
        vecs[12] = '{1,  6,  0,    65535, 16, 0,  0,   65536,      127, 1};
        vecs[13] = '{1,  7,  0,    1,     1, 0,   1,   -1,         0,   0};
        vecs[14] = '{1,  7,  0,    1,     1, 0,   0,   -1,         -1,  0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(out_valid == 1'b0 && out_data == '0 && out_ch == '0 && out_sat == 1'b0 && in_ready == 1'b1,
            $sformatf("reset got v=%b ch=%0d sat=%b rdy=%b data=%h want v=0 ch=0 sat=0 rdy=1 data=0",
                      out_valid, out_ch, out_sat, in_ready, out_data));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 15; v++) begin
            if (vecs[v].do_cfg != 0) begin
                cfg_wr(0, vecs[v].ch, vecs[v].bias);
                cfg_wr(1, vecs[v].ch, vecs[v].scale);
                cfg_wr(2, vecs[v].ch, vecs[v].shift);
            end
            send_one(vecs[v].ch, fill(vecs[v].acc), vecs[v].relu, vecs[v].rnd, lat);
            ok = (lat == 3) && (out_sat == (vecs[v].sat != 0)) && lanes_eq(vecs[v].expv)
                 && (int'(out_ch) == vecs[v].ch);
            chk(ok, $sformatf("vec%0d got lane0=%0d sat=%b lat=%0d ch=%0d want %0d sat=%0d lat=3 ch=%0d",
                              v, $signed(out_data[OUT_W-1:0]), out_sat, lat, out_ch,
                              vecs[v].expv, vecs[v].sat, vecs[v].ch));
            @(posedge clk);
            #1;
        end

        // Write and accept on the same channel in the same cycle
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = CH_AW'(1); cfg_data = 16'd5;
        in_valid = 1'b1; in_ch = CH_AW'(1); in_data = fill(40); relu_en = 1'b0; round_en = 1'b0;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        got[0] = 0; got[1] = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got[n] = int'($signed(out_data[OUT_W-1:0]));
                n++;
            end
        end
        chk(n == 2 && got[0] == 40 && got[1] == 45,
            $sformatf("cfg_same_cycle got n=%0d %0d,%0d want 2 40,45", n, got[0], got[1]));
        @(posedge clk);
        #1;

        // Back-to-back beats with downstream stalls
        sent = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_ch = CH_AW'($urandom);
        in_data = rand_data();
        relu_en = 1'($urandom);
        round_en = 1'($urandom);
        for (int c = 0; c < 200 && sent < 10; c++) begin
            if (c >= 4) out_ready = (pat[(c - 4) % 6] != 0);
            @(negedge clk);
            if (c == 3)
                chk(in_ready == 1'b0 && sent == 3,
                    $sformatf("full got in_ready=%b accepted=%0d want 0 3", in_ready, sent));
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            in_ch = CH_AW'($urandom);
            in_data = rand_data();
        end
        in_valid = 1'b0;
        chk(sent == 10, $sformatf("bp_sent got %0d want 10", sent));
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = CH_AW'(1); in_data = fill(40); relu_en = 1'b0; round_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        model_defaults();
        #1;
        chk(out_valid == 1'b0, $sformatf("rst_async got v=%b want 0", out_valid));
        @(negedge clk);
        chk(out_valid == 1'b0 && out_data == '0 && out_sat == 1'b0 && out_ch == '0,
            $sformatf("rst_mid got v=%b ch=%0d sat=%b data=%h want 0 0 0 0",
                      out_valid, out_ch, out_sat, out_data));
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_one(1, fill(40), 0, 0, lat);
        chk(lat == 3 && lanes_eq(40),
            $sformatf("rst_table got lane0=%0d lat=%0d want 40 lat=3",
                      $signed(out_data[OUT_W-1:0]), lat));
        @(posedge clk);
        #1;

        // Randomised traffic, config churn and backpressure against the model
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_AW'($urandom);
            in_data   = rand_data();
            relu_en   = 1'($urandom);
            round_en  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_sel   = 2'($urandom);
            cfg_addr  = CH_AW'($urandom);
            cfg_data  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
